// File: rtl/prgmem_pkg.sv
// Shared constants for the program-ROM mode controller: FSM encoding and default widths.
package prgmem_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PROG  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;
endpackage

// File: rtl/prgmem_hold_cnt.sv
// Loadable down-counter that times the post-programming CPU reset hold.
module prgmem_hold_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Reset and load both start a fresh hold window; counting stops at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r <= value;
    end else if (load) begin
      cnt_r <= value;
    end else if (en && !zero) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});
endmodule

// File: rtl/prgmem_mode_ctrl.sv
// Owns the instruction-ROM port and sequences RUN / PROG / DRAIN / HOLD.
// Optional sequential-address write checker enabled by PRGMEM_WRCHK_EN.
module prgmem_mode_ctrl
  import prgmem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int HOLD_CYC = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              prog_req,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_adr_i,
  input  logic [DATA_W-1:0] upg_dat_i,
  input  logic              upg_done_i,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  output logic              upg_rst_o,
  output logic              cpu_rst_o,
  output logic              prog_busy,
  output logic [ADDR_W:0]   words_wr,
  output logic              err
);
  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0]  WR_ONE    = (ADDR_W + 1)'(1);

  logic [1:0]      state_r;
  logic [1:0]      state_nx_s;
  logic            prog_q_r;
  logic            hold_load_s;
  logic            hold_zero_s;
  logic            abort_s;
  logic            enter_prog_s;
  logic            wr_s;
  logic            chk_err_s;
  logic [ADDR_W:0] words_wr_r;
  logic            err_r;

  prgmem_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (hold_load_s),
    .en      (state_r == ST_HOLD),
    .value   (HOLD_LOAD),
    .zero    (hold_zero_s)
  );

  // Next-state logic; PROG entry needs a fresh prog_req edge, done beats abort.
  always_comb begin
    state_nx_s  = state_r;
    hold_load_s = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (prog_req && !prog_q_r) state_nx_s = ST_PROG;
        else                       state_nx_s = ST_RUN;
      end
      ST_PROG: begin
        if (upg_done_i) begin
          state_nx_s = ST_DRAIN;
        end else if (!prog_req) begin
          state_nx_s  = ST_HOLD;
          hold_load_s = 1'b1;
          abort_s     = 1'b1;
        end else begin
          state_nx_s = ST_PROG;
        end
      end
      ST_DRAIN: begin
        state_nx_s  = ST_HOLD;
        hold_load_s = 1'b1;
      end
      ST_HOLD: begin
        if (hold_zero_s) state_nx_s = ST_RUN;
        else             state_nx_s = ST_HOLD;
      end
      default: begin
        state_nx_s  = ST_HOLD;
        hold_load_s = 1'b1;
      end
    endcase
  end

  assign enter_prog_s = (state_r == ST_RUN) && (state_nx_s == ST_PROG);
  assign wr_s         = (state_r == ST_PROG) && upg_wen_i;

`ifdef PRGMEM_WRCHK_EN
  localparam logic [ADDR_W-1:0] ADR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] last_adr_r;
  logic              seen_r;

  // A session must write 0,1,2,... with nothing after the top address.
  always_comb begin
    chk_err_s = 1'b0;
    if (wr_s) begin
      if (!seen_r)                    chk_err_s = (upg_adr_i != {ADDR_W{1'b0}});
      else if (last_adr_r == ADR_MAX) chk_err_s = 1'b1;
      else                            chk_err_s = (upg_adr_i != last_adr_r + ADR_ONE);
    end else begin
      chk_err_s = 1'b0;
    end
  end

  // Track the previous write address within the current session.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_adr_r <= {ADDR_W{1'b0}};
      seen_r     <= 1'b0;
    end else if (enter_prog_s) begin
      last_adr_r <= {ADDR_W{1'b0}};
      seen_r     <= 1'b0;
    end else if (wr_s) begin
      last_adr_r <= upg_adr_i;
      seen_r     <= 1'b1;
    end else begin
      last_adr_r <= last_adr_r;
      seen_r     <= seen_r;
    end
  end
`else
  assign chk_err_s = 1'b0;
`endif

  // State, request edge history, saturating write count and sticky error.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r    <= ST_HOLD;
      prog_q_r   <= 1'b0;
      words_wr_r <= {(ADDR_W + 1){1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      prog_q_r <= prog_req;
      if (enter_prog_s)                   words_wr_r <= {(ADDR_W + 1){1'b0}};
      else if (wr_s && !words_wr_r[ADDR_W]) words_wr_r <= words_wr_r + WR_ONE;
      else                                words_wr_r <= words_wr_r;
      if (abort_s || chk_err_s) err_r <= 1'b1;
      else                      err_r <= err_r;
    end
  end

  // ROM port mux decodes registered state only, so the fetch path sees no extra stage.
  always_comb begin
    if (state_r == ST_PROG) begin
      mem_addra = upg_adr_i;
      mem_dina  = upg_dat_i;
      mem_wea   = upg_wen_i;
    end else begin
      mem_addra = cpu_addr;
      mem_dina  = {DATA_W{1'b0}};
      mem_wea   = 1'b0;
    end
  end

  assign cpu_rst_o = (state_r != ST_RUN);
  assign upg_rst_o = (state_r != ST_PROG);
  assign prog_busy = (state_r == ST_PROG) || (state_r == ST_DRAIN);
  assign words_wr  = words_wr_r;
  assign err       = err_r;
endmodule
